// File: rtl/xadc_scan_sequencer.sv
// xadc_scan_sequencer: steps an external analog mux across NUM_CHANNELS
// inputs. For each channel it waits out a settling time, waits for an XADC
// end-of-conversion, reads the VP/VN status register over DRP and emits a
// 12-bit sample tagged with its channel number. All outputs are registered.
module xadc_scan_sequencer #(
  parameter int         NUM_CHANNELS   = 4,
  parameter int         SETTLE_CYCLES  = 256,
  parameter logic [6:0] DRP_ADDR       = 7'h03,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [4:0]  XADC_MUXADDR,
  input  logic        xadc_eoc,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [4:0]  sample_chan
);

  // One counter serves both the settle window and the DRDY timeout.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    LAST_CH  = 5'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_EOC, S_DRP_RD, S_WAIT_DRDY, S_EMIT
  } state_t;

  state_t          r_state, w_nstate;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_chan;
  logic            r_eoc;
  logic            r_stop_pend;
  logic            r_busy, r_done, r_terr, r_den, r_svalid;
  logic [4:0]      r_mux, r_schan;
  logic [6:0]      r_daddr;
  logic [11:0]     r_sdata;
  logic            w_timeout;
  logic            w_last;
  logic            w_stop_eff;
  logic            w_accept;
  logic            w_unused;

  assign w_last     = (r_chan == LAST_CH);
  // A stop arriving in the very cycle of the final EMIT still ends the scan.
  assign w_stop_eff = r_stop_pend | stop;
  assign w_accept   = (r_state == S_IDLE) && start;
  // Low nibble of the status word is below the 12-bit ADC resolution.
  assign w_unused   = ^drp_do[3:0];

  // State register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_nstate;
  end

  // Next-state logic and timeout detection.
  always_comb begin
    w_nstate  = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:      if (start) w_nstate = S_SETTLE;
      S_SETTLE:    if (r_cnt == SET_LAST) w_nstate = S_WAIT_EOC;
      // r_eoc only holds pulses seen while already waiting, so a conversion
      // that finished during settling can never be mistaken for this one.
      S_WAIT_EOC:  if (r_eoc) w_nstate = S_DRP_RD;
      S_DRP_RD:    w_nstate = S_WAIT_DRDY;
      S_WAIT_DRDY: begin
        if (drp_drdy) begin
          w_nstate = S_EMIT;
        end else if (r_cnt >= TO_LAST) begin
          w_nstate  = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_EMIT: begin
        if (!w_last || (continuous && !w_stop_eff)) w_nstate = S_SETTLE;
        else                                        w_nstate = S_IDLE;
      end
      default:     w_nstate = S_IDLE;
    endcase
  end

  // Settle / timeout counter; the timeout count starts at 1 on leaving
  // DRP_RD so it measures clocks since drp_den was high.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                                      r_cnt <= '0;
    else if (r_state == S_DRP_RD)                            r_cnt <= CW'(1);
    else if (w_nstate != r_state)                            r_cnt <= '0;
    else if (r_state == S_SETTLE || r_state == S_WAIT_DRDY)  r_cnt <= r_cnt + CW'(1);
    else                                                     r_cnt <= '0;
  end

  // EOC capture, qualified by the waiting state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_eoc <= 1'b0;
    else                r_eoc <= xadc_eoc && (r_state == S_WAIT_EOC);
  end

  // Channel pointer and mux select; both move only when entering SETTLE.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_chan <= '0;
      r_mux  <= '0;
    end else if (w_accept) begin
      r_chan <= '0;
      r_mux  <= '0;
    end else if (r_state == S_EMIT && w_nstate == S_SETTLE) begin
      r_chan <= w_last ? 5'd0 : r_chan + 5'd1;
      r_mux  <= w_last ? 5'd0 : r_chan + 5'd1;
    end
  end

  // Stop request and sticky timeout flag; a new scan clears both.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_stop_pend <= 1'b0;
      r_terr      <= 1'b0;
    end else if (w_accept) begin
      r_stop_pend <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      if (stop && r_state != S_IDLE) r_stop_pend <= 1'b1;
      if (w_timeout)                 r_terr      <= 1'b1;
    end
  end

  // Status and DRP strobes, registered from the next state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_den    <= 1'b0;
      r_daddr  <= '0;
      r_svalid <= 1'b0;
    end else begin
      r_busy   <= (w_nstate != S_IDLE);
      r_done   <= (r_state == S_EMIT) && (w_nstate == S_IDLE);
      r_den    <= (w_nstate == S_DRP_RD);
      r_daddr  <= (w_nstate == S_DRP_RD) ? DRP_ADDR : 7'd0;
      r_svalid <= (w_nstate == S_EMIT);
    end
  end

  // Sample capture on DRDY while waiting for it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_sdata <= '0;
      r_schan <= '0;
    end else if (r_state == S_WAIT_DRDY && drp_drdy) begin
      r_sdata <= drp_do[15:4];
      r_schan <= r_chan;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_err  = r_terr;
  assign XADC_MUXADDR = r_mux;
  assign drp_daddr    = r_daddr;
  assign drp_den      = r_den;
  assign drp_dwe      = 1'b0;
  assign drp_di       = 16'd0;
  assign sample_valid = r_svalid;
  assign sample_data  = r_sdata;
  assign sample_chan  = r_schan;

endmodule

// File: tb/tb_xadc_scan_sequencer.sv
// Scoreboard bench for xadc_scan_sequencer: tests push the expected sample
// sequence (channel k mod N, data from a per-scan table), a DRP responder and
// EOC generator model the XADC, and a monitor pops and compares each sample.
module tb_xadc_scan_sequencer;
  localparam int NCH = 4, SET = 4, TMO = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, continuous = 1'b0, stop = 1'b0;
  logic        xadc_eoc = 1'b0, drp_drdy = 1'b0;
  logic [15:0] drp_do = 16'd0;
  logic        busy, done, timeout_err, drp_den, drp_dwe, sample_valid;
  logic [4:0]  mux, sample_chan;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [11:0] sample_data;

  xadc_scan_sequencer #(.NUM_CHANNELS(NCH), .SETTLE_CYCLES(SET), .DRP_ADDR(7'h03),
                        .TIMEOUT_CYCLES(TMO)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .continuous(continuous),
    .stop(stop), .busy(busy), .done(done), .timeout_err(timeout_err),
    .XADC_MUXADDR(mux), .xadc_eoc(xadc_eoc), .drp_daddr(drp_daddr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_chan(sample_chan));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] d; logic [4:0] c; } smp_t;
  smp_t        exp_q[$];
  logic [15:0] data_tab[16];
  int errors = 0, checks = 0;
  int den_k = 0, withhold = -1, late = 0, lat = 2, eoc_mode = 0, lat_chk = 0;
  int n_samp = 0, done_cnt = 0, den_cyc = 0, last_mux_cyc = 0;
  int pend = 0;
  logic [15:0] pend_d = 16'd0;
  logic [4:0]  prev_mux = 5'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // EOC generator: random sparse pulses or a pulse every cycle.
  initial forever @(negedge clk)
    xadc_eoc = (eoc_mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);

  // DRP responder: answers the k-th drp_den of a scan with data_tab[k] after
  // lat cycles; the withheld index gets no answer or a very late one.
  initial forever @(negedge clk) begin
    if (mux !== prev_mux) begin
      last_mux_cyc = cyc;
      prev_mux     = mux;
    end
    drp_drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drp_drdy = 1'b1;
        drp_do   = pend_d;
      end
    end
    if (drp_den === 1'b1) begin
      den_cyc = cyc;
      chk("den_mux", mux, 32'(den_k % NCH));
      chk("den_addr", drp_daddr, 32'h03);
      if (lat_chk != 0) chk("den_latency", cyc - last_mux_cyc, SET + 2);
      if (den_k == withhold) begin
        if (late > 0) begin pend = late; pend_d = 16'hFFFF; end
      end else begin
        pend   = lat;
        pend_d = data_tab[den_k % 16];
      end
      den_k++;
    end
  end

  // Monitor: scoreboard pop on every sample, consistency on every done.
  initial forever @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      n_samp++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_sample: got chan %0d data %0h, expected none", sample_chan, sample_data);
      end else begin
        smp_t e;
        e = exp_q.pop_front();
        chk("sample_data", sample_data, e.d);
        chk("sample_chan", sample_chan, e.c);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_vs_valid", sample_valid, 0);
      chk("done_q_empty", exp_q.size(), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // New scan: fill data table, reset responder index, push expectations.
  task automatic prep(input int n_exp, input int pattern, input int wh, input int lt);
    withhold = wh; late = lt; den_k = 0;
    for (int k = 0; k < 16; k++)
      data_tab[k] = (pattern != 0) ? 16'hABC0 + 16'((k % NCH) * 16) : 16'($urandom);
    for (int k = 0; k < n_exp; k++) begin
      smp_t e;
      e.d = data_tab[k] >> 4;
      e.c = 5'(k % NCH);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string nm);
    int d0, i;
    d0 = done_cnt; i = 0;
    while (done_cnt == d0 && i < 2000) begin @(negedge clk); i++; end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL %s: got no done within 2000 cycles, expected done", nm);
    end
  endtask

  task automatic wait_den(input int k);
    int i;
    i = 0;
    while (den_k < k && i < 2000) begin @(negedge clk); i++; end
    if (den_k < k) begin
      checks++; errors++;
      $display("FAIL wait_den: got %0d dens, expected %0d", den_k, k);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_terr"}, timeout_err, 0);
    chk({nm, "_mux"}, mux, 0);
    chk({nm, "_den"}, drp_den, 0);
    chk({nm, "_daddr"}, drp_daddr, 0);
    chk({nm, "_svalid"}, sample_valid, 0);
    chk({nm, "_sdata"}, sample_data, 0);
    chk({nm, "_schan"}, sample_chan, 0);
    chk({nm, "_dwe"}, drp_dwe, 0);
    chk({nm, "_di"}, drp_di, 0);
  endtask

  // Full scan with end-of-scan bookkeeping checks.
  task automatic run_scan(input string nm, input int n_exp);
    int s0, d0;
    s0 = n_samp; d0 = done_cnt;
    pulse_start();
    wait_done(nm);
    tick(3);
    chk({nm, "_samples"}, n_samp - s0, n_exp);
    chk({nm, "_dones"}, done_cnt - d0, 1);
    chk({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int s0, d0, i, cont, j, n;
    tick(3);
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // Single scan with fixed data pattern.
    prep(4, 1, -1, 0);
    run_scan("single", 4);

    // EOC every cycle: sampling latency after each mux change.
    eoc_mode = 1; lat_chk = 1;
    prep(4, 0, -1, 0);
    run_scan("eoc_latency", 4);
    lat_chk = 0; eoc_mode = 0;

    // Continuous, stop during channel 1 of the second pass.
    prep(8, 0, -1, 0);
    continuous = 1'b1;
    s0 = n_samp; d0 = done_cnt;
    pulse_start();
    wait_den(6);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    wait_done("cont_stop");
    continuous = 1'b0;
    tick(3);
    chk("cont_stop_samples", n_samp - s0, 8);
    chk("cont_stop_dones", done_cnt - d0, 1);

    // DRDY withheld on channel 2: timeout, abort, next start clears flag.
    prep(2, 0, 2, 0);
    s0 = n_samp; d0 = done_cnt;
    pulse_start();
    i = 0;
    while (timeout_err !== 1'b1 && i < 2000) begin @(negedge clk); i++; end
    chk("timeout_seen", timeout_err, 1);
    chk("timeout_delay", cyc - den_cyc, TMO);
    chk("timeout_busy", busy, 0);
    tick(5);
    chk("timeout_dones", done_cnt - d0, 0);
    chk("timeout_samples", n_samp - s0, 2);
    chk("timeout_sticky", timeout_err, 1);
    prep(4, 0, -1, 0);
    s0 = n_samp;
    pulse_start();
    chk("timeout_cleared", timeout_err, 0);
    chk("restart_busy", busy, 1);
    wait_done("after_timeout");
    tick(3);
    chk("after_timeout_samples", n_samp - s0, 4);

    // Reset during WAIT_DRDY, late DRDY must be ignored.
    prep(2, 0, 2, 10);
    s0 = n_samp; d0 = done_cnt;
    pulse_start();
    wait_den(3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midreset");
    tick(2);
    rst_n = 1'b1;
    s0 = n_samp;
    tick(15);
    chk("late_drdy_samples", n_samp - s0, 0);
    chk("late_drdy_busy", busy, 0);
    chk("reset_q_empty", exp_q.size(), 0);
    prep(4, 0, -1, 0);
    run_scan("after_reset", 4);

    // start during SETTLE of channel 1 is ignored.
    prep(4, 0, -1, 0);
    s0 = n_samp; d0 = done_cnt;
    pulse_start();
    i = 0;
    while (n_samp < s0 + 1 && i < 2000) begin @(negedge clk); i++; end
    pulse_start();
    wait_done("start_ignored");
    tick(3);
    chk("start_ignored_samples", n_samp - s0, 4);
    chk("start_ignored_dones", done_cnt - d0, 1);

    // Random scans: EOC pattern, DRDY latency, data, optional stop point.
    for (int it = 0; it < 6; it++) begin
      cont     = $urandom_range(0, 1);
      j        = $urandom_range(1, 7);
      lat      = $urandom_range(1, 6);
      eoc_mode = $urandom_range(0, 1);
      n        = (cont != 0) ? NCH * ((j - 1) / NCH + 1) : NCH;
      prep(n, 0, -1, 0);
      continuous = (cont != 0);
      s0 = n_samp;
      pulse_start();
      if (cont != 0) begin
        wait_den(j);
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
      end
      wait_done("random");
      continuous = 1'b0;
      tick(3);
      chk("random_samples", n_samp - s0, n);
    end

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
